rx_nibble_serializer: RTL and testbench

Sits between the RX sample FIFO read port (24-bit I/Q words with tlast and fill level) and the Pi-facing 4-bit RX data pins. It converts each 24-bit word into six 4-bit nibbles, most-significant nibble first, advancing one nibble per synchronized Pi request. It asserts a last marker on the final nibble of a tlast word and generates the hysteresis "samples available" flag for the Pi. A two-entry buffer (current and next) gives zero-bubble streaming across word boundaries; underruns are counted.

---
 rtl/rx_serial_pkg.sv | 12 +
 rtl/rx_fill_hysteresis.sv | 19 +
 rtl/rx_nibble_serializer.sv | 107 ++++++++++
 tb/tb_rx_nibble_serializer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_serial_pkg.sv
// rx_serial_pkg: shared state type, constants and nibble helper for the RX nibble serializer
package rx_serial_pkg;
  localparam int WORD_W = 24;
  localparam int NIB_W = 4;
  localparam int NIBS_PER_WORD = WORD_W / NIB_W;
  localparam int IDX_W = $clog2(NIBS_PER_WORD);
  localparam logic [7:0] UNDERRUN_MAX = 8'hFF;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic logic [NIB_W-1:0] nibble_select(input logic [WORD_W-1:0] word, input logic [IDX_W-1:0] idx);
    return word[WORD_W-1-NIB_W*idx -: NIB_W];
  endfunction
endpackage

// File: rtl/rx_fill_hysteresis.sv
// rx_fill_hysteresis: registered samples-available flag with high/low fill thresholds
module rx_fill_hysteresis #(
  parameter int LW = 11,
  parameter int THRESH_HI = 256,
  parameter int THRESH_LO = 128
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [LW-1:0] in_fill,
  output logic          samples_avail
);
  logic r_avail;
  assign samples_avail = r_avail;
  // set above the high mark, clear below the low mark, hold in the band and on either mark
  always_ff @(posedge clk) begin
    if (!rstb) r_avail <= 1'b0;
    else r_avail <= in_fill > LW'(THRESH_HI) ? 1'b1 : in_fill < LW'(THRESH_LO) ? 1'b0 : r_avail;
  end
endmodule

// File: rtl/rx_nibble_serializer.sv
// rx_nibble_serializer: 24-bit FIFO words to MS-first nibbles on Pi request; RX_NIBBLE_PARITY_EN adds out_parity
module rx_nibble_serializer
  import rx_serial_pkg::*;
#(
  parameter int DW = 24,
  parameter int NW = 4,
  parameter int LW = 11,
  parameter int THRESH_HI = 256,
  parameter int THRESH_LO = 128
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [DW-1:0] in_tdata,
  input  logic          in_tvalid,
  input  logic          in_tlast,
  output logic          in_tready,
  input  logic [LW-1:0] in_fill,
  input  logic          nib_req,
  output logic [NW-1:0] out_data,
  output logic          out_last,
  output logic          out_valid,
  output logic          samples_avail,
  output logic          underrun,
  output logic [7:0]    underrun_cnt,
  input  logic          clr_status
`ifdef RX_NIBBLE_PARITY_EN
  , output logic        out_parity
`endif
);
  localparam int NIBS = DW / NW;
  localparam int IW = $clog2(NIBS);
  state_t r_state, w_state_nxt;
  logic [DW-1:0] r_cur, r_nxt;
  logic r_cur_last, r_nxt_last, r_nxt_valid;
  logic [IW-1:0] r_idx;
  logic [NW-1:0] r_out_data;
  logic r_out_last, r_out_valid, r_underrun;
  logic [7:0] r_ucnt;
  logic w_stream, w_last_nib, w_end, w_move, w_accept;
  assign in_tready = rstb & ~r_nxt_valid;
  assign out_data = r_out_data;
  assign out_last = r_out_last;
  assign out_valid = r_out_valid;
  assign underrun = r_underrun;
  assign underrun_cnt = r_ucnt;
  rx_fill_hysteresis #(.LW(LW), .THRESH_HI(THRESH_HI), .THRESH_LO(THRESH_LO)) u_hyst (
    .clk(clk), .rstb(rstb), .in_fill(in_fill), .samples_avail(samples_avail)
  );
  // next state: nxt moves into cur when cur is empty or its final nibble is being served
  always_comb begin
    w_stream = r_state == STREAM;
    w_last_nib = r_idx == IW'(NIBS - 1);
    w_end = w_stream & nib_req & w_last_nib;
    w_move = r_nxt_valid & (~w_stream | w_end);
    w_accept = in_tvalid & in_tready;
    w_state_nxt = w_move ? STREAM : w_end ? IDLE : r_state;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rstb) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  // word buffers, nibble index, nibble output and underrun status
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_cur <= '0;
      r_cur_last <= 1'b0;
      r_nxt <= '0;
      r_nxt_last <= 1'b0;
      r_nxt_valid <= 1'b0;
      r_idx <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_out_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_ucnt <= '0;
    end else begin
      r_nxt_valid <= w_accept | (r_nxt_valid & ~w_move);
      if (w_accept) begin
        r_nxt <= in_tdata;
        r_nxt_last <= in_tlast;
      end
      if (w_move) begin
        r_cur <= r_nxt;
        r_cur_last <= r_nxt_last;
      end
      if (w_move | w_end) r_idx <= '0;
      else if (w_stream & nib_req) r_idx <= r_idx + 1'b1;
      r_out_valid <= nib_req;
      if (nib_req) begin
        r_out_data <= w_stream ? r_cur[DW-1-NW*r_idx -: NW] : '0;
        r_out_last <= w_end & r_cur_last;
      end
      r_underrun <= clr_status ? 1'b0 : r_underrun | (nib_req & ~w_stream);
      r_ucnt <= clr_status ? '0 : (nib_req & ~w_stream & r_ucnt != UNDERRUN_MAX) ? r_ucnt + 8'd1 : r_ucnt;
    end
  end
`ifdef RX_NIBBLE_PARITY_EN
  logic r_out_parity;
  assign out_parity = r_out_parity;
  // word parity rides on the first nibble only; underrun and later nibbles carry 0
  always_ff @(posedge clk) begin
    if (!rstb) r_out_parity <= 1'b0;
    else if (nib_req) r_out_parity <= w_stream & (r_idx == '0) & (^r_cur);
  end
`endif
endmodule

// File: tb/tb_rx_nibble_serializer.sv
// tb_rx_nibble_serializer: scoreboard bench for rx_nibble_serializer
module tb_rx_nibble_serializer;
  logic clk = 1'b0, rstb = 1'b0;
  logic [23:0] in_tdata = '0;
  logic in_tvalid = 1'b0, in_tlast = 1'b0, in_tready;
  logic [10:0] in_fill = '0;
  logic nib_req = 1'b0, clr_status = 1'b0;
  logic [3:0] out_data;
  logic out_last, out_valid, samples_avail, underrun;
  logic [7:0] underrun_cnt;
`ifdef RX_NIBBLE_PARITY_EN
  logic out_parity;
`endif
  logic [6:0] q[$];
  logic [6:0] exp_v;
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  rx_nibble_serializer dut (
    .clk(clk), .rstb(rstb), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready), .in_fill(in_fill), .nib_req(nib_req), .out_data(out_data),
    .out_last(out_last), .out_valid(out_valid), .samples_avail(samples_avail),
    .underrun(underrun), .underrun_cnt(underrun_cnt), .clr_status(clr_status)
`ifdef RX_NIBBLE_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [6:0] got();
`ifdef RX_NIBBLE_PARITY_EN
    return {out_valid, out_parity, out_last, out_data};
`else
    return {out_valid, 1'b0, out_last, out_data};
`endif
  endfunction

  function automatic logic [6:0] pop();
    return q.size() != 0 ? q.pop_front() : 7'h00;
  endfunction

  task automatic push_word(input logic [23:0] w, input logic last);
    int t = 0;
    in_tdata = w;
    in_tlast = last;
    in_tvalid = 1'b1;
    while (!in_tready && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_total++;
    if (in_tready !== 1'b1) $display("FAIL push_ready word=%h got tready=%b exp 1", w, in_tready);
    else n_pass++;
    @(negedge clk);
    in_tvalid = 1'b0;
    for (int k = 0; k < 6; k++) begin
`ifdef RX_NIBBLE_PARITY_EN
      q.push_back({1'b1, k == 0 ? ^w : 1'b0, last && k == 5, 4'(w >> (20 - 4 * k))});
`else
      q.push_back({1'b1, 1'b0, last && k == 5, 4'(w >> (20 - 4 * k))});
`endif
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({out_data, out_last, out_valid, samples_avail, underrun, underrun_cnt} !== 16'h0)
      $display("FAIL reset_outputs got d=%h l=%b v=%b sa=%b u=%b c=%0d exp all 0", out_data, out_last, out_valid, samples_avail, underrun, underrun_cnt);
    else n_pass++;
    n_total++;
    if (in_tready !== 1'b0) $display("FAIL reset_tready got %b exp 0", in_tready);
    else n_pass++;
    rstb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    push_word(24'hABCDEF, 1'b1);
    @(negedge clk);
    nib_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_v = pop();
      n_total++;
      if (got() !== exp_v) $display("FAIL single_nib%0d got %h exp %h", k, got(), exp_v);
      else n_pass++;
    end
    nib_req = 1'b0;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_last, out_data} !== 6'b0_1_1111) $display("FAIL single_hold got v=%b l=%b d=%h exp v=0 l=1 d=f", out_valid, out_last, out_data);
    else n_pass++;
    nib_req = 1'b1;
    @(negedge clk);
    nib_req = 1'b0;
    n_total++;
    if ({out_valid, out_last, out_data, underrun, underrun_cnt} !== {6'b1_0_0000, 1'b1, 8'd1})
      $display("FAIL single_idle got v=%b l=%b d=%h u=%b c=%0d exp v=1 l=0 d=0 u=1 c=1", out_valid, out_last, out_data, underrun, underrun_cnt);
    else n_pass++;
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  task automatic test_back_to_back();
    push_word(24'h123456, 1'b0);
    push_word(24'h789ABC, 1'b1);
    nib_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_v = pop();
      n_total++;
      if (got() !== exp_v) $display("FAIL b2b_nib%0d got %h exp %h", k, got(), exp_v);
      else n_pass++;
      if (k == 4) begin
        n_total++;
        if (in_tready !== 1'b0) $display("FAIL b2b_tready_full got %b exp 0", in_tready);
        else n_pass++;
      end
      if (k == 5) begin
        n_total++;
        if (in_tready !== 1'b1) $display("FAIL b2b_tready_freed got %b exp 1", in_tready);
        else n_pass++;
      end
    end
    nib_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_underrun();
    repeat (3) q.push_back(7'b1_0_0_0000);
    nib_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_v = pop();
      n_total++;
      if (got() !== exp_v) $display("FAIL underrun_nib%0d got %h exp %h", k, got(), exp_v);
      else n_pass++;
    end
    nib_req = 1'b0;
    n_total++;
    if ({underrun, underrun_cnt} !== {1'b1, 8'd3}) $display("FAIL underrun_status got u=%b c=%0d exp u=1 c=3", underrun, underrun_cnt);
    else n_pass++;
    clr_status = 1'b1;
    nib_req = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    nib_req = 1'b0;
    n_total++;
    if ({underrun, underrun_cnt, out_valid, out_data} !== {1'b0, 8'd0, 1'b1, 4'h0})
      $display("FAIL underrun_clear got u=%b c=%0d v=%b d=%h exp u=0 c=0 v=1 d=0", underrun, underrun_cnt, out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_fill();
    int fills[9] = '{0, 256, 257, 300, 256, 200, 128, 127, 128};
    logic e = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_fill = 11'(fills[k]);
      @(negedge clk);
      e = fills[k] > 256 ? 1'b1 : fills[k] < 128 ? 1'b0 : e;
      n_total++;
      if (samples_avail !== e) $display("FAIL fill_%0d got %b exp %b", fills[k], samples_avail, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midword();
    in_fill = '0;
    push_word(24'hFEDCBA, 1'b1);
    @(negedge clk);
    nib_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_v = pop();
      n_total++;
      if (got() !== exp_v) $display("FAIL midword_nib%0d got %h exp %h", k, got(), exp_v);
      else n_pass++;
    end
    nib_req = 1'b0;
    q.delete();
    rstb = 1'b0;
    in_tvalid = 1'b1;
    @(negedge clk);
    n_total++;
    if ({out_data, out_last, out_valid, samples_avail, underrun, underrun_cnt, in_tready} !== 17'h0)
      $display("FAIL midword_reset got d=%h l=%b v=%b sa=%b u=%b c=%0d rdy=%b exp all 0", out_data, out_last, out_valid, samples_avail, underrun, underrun_cnt, in_tready);
    else n_pass++;
    in_tvalid = 1'b0;
    rstb = 1'b1;
    @(negedge clk);
    push_word(24'h000001, 1'b1);
    @(negedge clk);
    nib_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_v = pop();
      n_total++;
      if (got() !== exp_v) $display("FAIL after_reset_nib%0d got %h exp %h", k, got(), exp_v);
      else n_pass++;
    end
    nib_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    nib_req = 1'b1;
    repeat (255) @(negedge clk);
    n_total++;
    if (underrun_cnt !== 8'd255) $display("FAIL sat_255 got %0d exp 255", underrun_cnt);
    else n_pass++;
    repeat (45) @(negedge clk);
    nib_req = 1'b0;
    n_total++;
    if ({underrun, underrun_cnt} !== {1'b1, 8'd255}) $display("FAIL sat_300 got u=%b c=%0d exp u=1 c=255", underrun, underrun_cnt);
    else n_pass++;
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  task automatic test_parity();
    push_word(24'h000007, 1'b1);
    @(negedge clk);
    nib_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_v = pop();
      n_total++;
      if (got() !== exp_v) $display("FAIL parity_nib%0d got %h exp %h", k, got(), exp_v);
      else n_pass++;
    end
    nib_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_fill();
    test_reset_midword();
    test_saturate();
    test_parity();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
